score_display: RTL and testbench
================================

Name: score_display

Overview:
- Consumer side of the game score counter: takes the 10-bit binary score and drives a 4-digit multiplexed 7-segment display.
- On an update request it converts the score to BCD with a sequential double-dabble engine, then latches the digits into display registers.
- A scan counter time-multiplexes the four digits onto the shared segment bus.
- Sits between the score counter and the board's 7-segment pins.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot; 1 kHz digit rate at 100 MHz; legal ≥ 2.
- BLANK_LZ, 1, 1 = blank leading zeros; digit 0 is never blanked.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- score  in  10  binary score, 0..1023; sampled only when an update is accepted.
- update  in  1  one-cycle request to refresh the displayed value.
- busy  out  1  conversion in progress (states CONV or DONE).
- an  out  4  digit enables, active-low, one-hot-zero; an[0] is the units digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset: both FSMs and the scan path clear asynchronously.
  - FSM = IDLE, busy=0, pending=0.
  - Display digits = 0,0,0,0; scan index = 0; scan count = 0.
  - an=4'b1110, seg=7'b1000000 (shows "0").
  - All outputs are registered.
- Conversion FSM states: IDLE, CONV, DONE.
- IDLE:
  - If update=1, latch score into the shift register, clear the 16-bit BCD accumulator and the bit counter, and go to CONV.
- CONV: exactly 10 cycles, one per score bit, MSB first. Each cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - After the 10th cycle, go to DONE.
- DONE: one cycle.
  - Copy the BCD nibbles into the display digit registers at the end of this cycle.
  - If pending=1, clear pending, latch the current score and go to CONV. Otherwise go to IDLE.
- Latency: update sampled at edge N gives busy=1 from N+1. New digits are visible on seg/an from edge N+12. busy=0 from N+12 when no pending request.
- update while busy:
  - Set pending; multiple requests collapse into one.
  - The score is re-sampled at the DONE cycle, not at the request.
  - The in-flight conversion is never aborted.
- Display digit registers change only in DONE. The display never shows a partially converted value.
- Maximum 1023 → digits 1,0,2,3. No overflow is possible and there is no saturation logic.
- Scan counter: counts 0..SCAN_DIV-1. On wrap it increments the scan index 0→1→2→3→0.
  - an has 0 at the index position.
  - seg is the decoded pattern of that digit, registered the same cycle as an.
- Blanking, when BLANK_LZ=1: digit k (k=3..1) is blank if it and all higher digits are 0.
  - A blank digit drives seg=7'b1111111; its an is still pulsed.
- Decoder patterns (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble values 10–15 are unreachable; they drive all-off.
- Reset mid-conversion: conversion is abandoned, the display returns to "0" and pending clears.
- The scan path runs independently of the conversion FSM.

Decomposition:
- Shared package holds:
  - FSM state encodings IDLE/CONV/DONE.
  - The ten segment pattern constants and SEG_BLANK.
  - Digit-count constant 4.
- Natural sub-module bin2bcd_seq: the IDLE/CONV/DONE double-dabble engine with start/busy/done and a 16-bit BCD output.
- score_display owns pending, the display registers, the scan counter, blanking and decode.

Test Plan:
1. Reset, SCAN_DIV=4 → an=1110, seg=1000000. an cycles 1110→1101→1011→0111→1110, one step every 4 clks. Digits 1–3 show seg=1111111.
2. score=1023, update at edge N → busy rises at N+1. Digits become 3,2,0,1 (units→thousands) at N+12, with no intermediate values. busy=0 at N+12.
3. score=47, BLANK_LZ=1 → an[0]:0010010? no: an[0] shows "7"=1111000, an[1] shows "4"=0011001, digits 2–3 blank. With BLANK_LZ=0, digits 2–3 show 1000000.
4. score=500, update; then at N+5 score=9 with update pulsed twice → pending set once. Display shows 500 at N+12, then 9 at N+23; busy stays high throughout.
5. score=1000 → digits 1,0,0,0. The internal zeros are not blanked: an[1], an[2] show 1000000.
6. Assert rst at N+6 during conversion of 888 → display "0" immediately. busy=0, pending=0, and no 888 ever appears.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: conversion FSM states,
// active-low segment patterns and the small BCD helper functions.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    localparam int NUM_DIGITS  = 4;
    localparam int BIN_W       = 10;
    localparam int BCD_W       = 16;

    // Segment patterns, bit order gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = res[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Score-counter-to-display link: score/update request plus busy and the
// multiplexed 7-segment pins.
interface score_display_if;
    import score_display_pkg::*;

    logic [BIN_W-1:0] score;
    logic             update;
    logic             busy;
    logic [3:0]       an;
    logic [6:0]       seg;

    modport master (
        output score,
        output update,
        input  busy,
        input  an,
        input  seg
    );

    modport slave (
        input  score,
        input  update,
        output busy,
        output an,
        output seg
    );
endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble engine: 10-bit binary to 4-digit BCD, one bit per
// cycle, with a one-cycle DONE state that can chain straight into a new start.
module score_display_bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_e      state_r;
    conv_state_e      state_s;
    logic [BIN_W-1:0] shift_r;
    logic [BCD_W-1:0] bcd_r;
    logic [BCD_W-1:0] bcd_adj_s;
    logic [3:0]       bit_cnt_r;
    logic             load_s;
    logic             step_s;

    assign bcd_adj_s = bcd_adjust(bcd_r);

    // Next-state and datapath control decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                step_s = 1'b1;
                if (bit_cnt_r == 4'(BIN_W - 1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and shift/accumulate datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bcd_r     <= '0;
            bit_cnt_r <= 4'd0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                shift_r   <= bin;
                bcd_r     <= '0;
                bit_cnt_r <= 4'd0;
            end else if (step_s) begin
                bcd_r     <= {bcd_adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
                shift_r   <= {shift_r[BIN_W-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign done = (state_r == ST_DONE);
    assign bcd  = bcd_r;

endmodule

// File: rtl/score_display.sv
// Score display top: collapses update requests into one pending slot, latches
// converted digits only on completion and scans them onto the 7-segment bus.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    score_display_if.slave bus
);

    localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic                             eng_busy_s;
    logic                             eng_done_s;
    logic [BCD_W-1:0]                 eng_bcd_s;
    logic                             start_s;
    logic                             pending_r;
    logic                             busy_r;
    logic [NUM_DIGITS-1:0][3:0]       digit_r;
    logic [CNT_W-1:0]                 scan_cnt_r;
    logic [1:0]                       scan_idx_r;
    logic [NUM_DIGITS-1:0]            blank_s;
    logic [3:0]                       an_s;
    logic [6:0]                       seg_s;
    logic [3:0]                       an_r;
    logic [6:0]                       seg_r;

    // A pending request restarts the engine directly out of DONE
    assign start_s = bus.update | pending_r;

    score_display_bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (bus.score),
        .busy  (eng_busy_s),
        .done  (eng_done_s),
        .bcd   (eng_bcd_s)
    );

    // Pending flag, busy flag and display digit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
            busy_r    <= 1'b0;
            digit_r   <= '0;
        end else begin
            busy_r <= eng_busy_s;
            if (eng_done_s) begin
                pending_r <= 1'b0;
                digit_r   <= eng_bcd_s;
            end else if (eng_busy_s && bus.update) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Digit-slot timer and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 2'd0;
        end else if (scan_cnt_r == CNT_LAST) begin
            scan_cnt_r <= '0;
            scan_idx_r <= scan_idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Leading-zero blanking; digit 0 always shows
    always_comb begin
        blank_s = '0;
        if (BLANK_LZ) begin
            blank_s[3] = (digit_r[3] == 4'd0);
            blank_s[2] = blank_s[3] && (digit_r[2] == 4'd0);
            blank_s[1] = blank_s[2] && (digit_r[1] == 4'd0);
        end else begin
            blank_s = '0;
        end
    end

    // Anode select and segment pattern for the current slot
    always_comb begin
        an_s  = 4'b1111;
        seg_s = SEG_BLANK;
        case (scan_idx_r)
            2'd0:    an_s = 4'b1110;
            2'd1:    an_s = 4'b1101;
            2'd2:    an_s = 4'b1011;
            2'd3:    an_s = 4'b0111;
            default: an_s = 4'b1111;
        endcase
        if (blank_s[scan_idx_r]) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(digit_r[scan_idx_r]);
        end
    end

    // Output pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 4'b1110;
            seg_r <= SEG_0;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.an   = an_r;
    assign bus.seg  = seg_r;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: two instances (blanking on/off) share the
// same stimulus; expected segment patterns are hand-written constants.
module tb_score_display;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] score_v;
    logic       update_v;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    score_display_if if_b ();
    score_display_if if_n ();

    assign if_b.score  = score_v;
    assign if_b.update = update_v;
    assign if_n.score  = score_v;
    assign if_n.update = update_v;

    score_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    score_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (if_n)
    );

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Collect one full scan of both instances
    task automatic capture(output logic [3:0][6:0] sb, output logic [3:0][6:0] sn, output bit ok);
        logic [3:0] mb;
        logic [3:0] mn;
        int ib;
        int inn;
        mb = 4'b0000;
        mn = 4'b0000;
        sb = '1;
        sn = '1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ib  = an_idx(if_b.an);
            inn = an_idx(if_n.an);
            if (ib >= 0) begin sb[ib] = if_b.seg; mb[ib] = 1'b1; end
            if (inn >= 0) begin sn[inn] = if_n.seg; mn[inn] = 1'b1; end
            if (mb == 4'hF && mn == 4'hF) break;
        end
        ok = (mb == 4'hF) && (mn == 4'hF);
    endtask

    task automatic pulse_update(input logic [9:0] val);
        @(negedge clk);
        score_v  = val;
        update_v = 1'b1;
        @(negedge clk);
        update_v = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0][6:0] gb, gn;
        bit ok;
        rst = 1'b1; score_v = 10'd0; update_v = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (if_b.an !== 4'b1110) begin n_bad++; $display("FAIL reset_an: got %b want 1110", if_b.an); end
        n_cmp++; if (if_b.seg !== P0) begin n_bad++; $display("FAIL reset_seg: got %b want %b", if_b.seg, P0); end
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if_b.busy); end
        n_cmp++; if (if_n.seg !== P0) begin n_bad++; $display("FAIL reset_seg_nb: got %b want %b", if_n.seg, P0); end
        rst = 1'b0;
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== {PB, PB, PB, P0}) begin n_bad++; $display("FAIL reset_disp_b: got %h want %h", gb, {PB, PB, PB, P0}); end
        n_cmp++; if (!ok || gn !== {P0, P0, P0, P0}) begin n_bad++; $display("FAIL reset_disp_nb: got %h want %h", gn, {P0, P0, P0, P0}); end
    endtask

    task automatic test_scan;
        logic [3:0] prev;
        logic [3:0] want;
        int first;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        prev = if_b.an;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_b.an !== prev) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL scan_step: got no change want change within 20 clk"); end
        first = an_idx(if_b.an);
        for (int j = 0; j < 16; j++) begin
            want = ~(4'b0001 << ((first + j / 4) % 4));
            n_cmp++; if (if_b.an !== want || if_n.an !== want) begin n_bad++; $display("FAIL scan_an[%0d]: got %b/%b want %b", j, if_b.an, if_n.an, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_max;
        logic [3:0][6:0] old_b, new_b, gb, gn;
        logic busy_n1, busy_n11;
        bit ok, stable;
        int ix;
        old_b = {PB, PB, PB, P0};
        new_b = {P1, P0, P2, P3};
        stable = 1'b1;
        pulse_update(10'd1023);
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL max_busy_N: got %b want 0", if_b.busy); end
        busy_n1 = 1'b0; busy_n11 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) busy_n1 = if_b.busy;
            if (k == 11) busy_n11 = if_b.busy;
            ix = an_idx(if_b.an);
            if (ix < 0 || if_b.seg !== old_b[ix]) stable = 1'b0;
        end
        n_cmp++; if (busy_n1 !== 1'b1) begin n_bad++; $display("FAIL max_busy_N1: got %b want 1", busy_n1); end
        n_cmp++; if (busy_n11 !== 1'b1) begin n_bad++; $display("FAIL max_busy_N11: got %b want 1", busy_n11); end
        n_cmp++; if (!stable) begin n_bad++; $display("FAIL max_no_partial: got changed display want old display until N+12"); end
        @(negedge clk);
        ix = an_idx(if_b.an);
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL max_busy_N12: got %b want 0", if_b.busy); end
        n_cmp++; if (ix < 0 || if_b.seg !== new_b[ix]) begin n_bad++; $display("FAIL max_seg_N12: got %b want new digit at slot %0d", if_b.seg, ix); end
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== new_b) begin n_bad++; $display("FAIL max_disp_b: got %h want %h", gb, new_b); end
        n_cmp++; if (!ok || gn !== new_b) begin n_bad++; $display("FAIL max_disp_nb: got %h want %h", gn, new_b); end
    endtask

    task automatic test_blank;
        logic [3:0][6:0] gb, gn;
        bit ok;
        pulse_update(10'd47);
        repeat (11) @(negedge clk);
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== {PB, PB, P4, P7}) begin n_bad++; $display("FAIL blank47_b: got %h want %h", gb, {PB, PB, P4, P7}); end
        n_cmp++; if (!ok || gn !== {P0, P0, P4, P7}) begin n_bad++; $display("FAIL blank47_nb: got %h want %h", gn, {P0, P0, P4, P7}); end
    endtask

    task automatic test_back_to_back;
        logic [3:0][6:0] t500, t9, gb, gn;
        bit busy_ok, ok500, ok;
        int ix;
        t500 = {PB, P5, P0, P0};
        t9   = {PB, PB, PB, P9};
        busy_ok = 1'b1; ok500 = 1'b1;
        pulse_update(10'd500);
        for (int k = 1; k <= 22; k++) begin
            update_v = (k == 5) || (k == 7);
            score_v  = (k >= 5) ? 10'd9 : 10'd500;
            @(negedge clk);
            if (if_b.busy !== 1'b1) busy_ok = 1'b0;
            ix = an_idx(if_b.an);
            if (k >= 12 && (ix < 0 || if_b.seg !== t500[ix])) ok500 = 1'b0;
        end
        update_v = 1'b0;
        n_cmp++; if (!busy_ok) begin n_bad++; $display("FAIL b2b_busy_high: got busy low want high N+1..N+22"); end
        n_cmp++; if (!ok500) begin n_bad++; $display("FAIL b2b_show500: got wrong segs want 500 during N+12..N+22"); end
        @(negedge clk);
        ix = an_idx(if_b.an);
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_N23: got %b want 0", if_b.busy); end
        n_cmp++; if (ix < 0 || if_b.seg !== t9[ix]) begin n_bad++; $display("FAIL b2b_seg_N23: got %b want digit of 9 at slot %0d", if_b.seg, ix); end
        repeat (4) @(negedge clk);
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_single_pending: got busy %b want 0", if_b.busy); end
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== t9) begin n_bad++; $display("FAIL b2b_disp9_b: got %h want %h", gb, t9); end
        n_cmp++; if (!ok || gn !== {P0, P0, P0, P9}) begin n_bad++; $display("FAIL b2b_disp9_nb: got %h want %h", gn, {P0, P0, P0, P9}); end
    endtask

    task automatic test_internal_zeros;
        logic [3:0][6:0] gb, gn;
        bit ok;
        pulse_update(10'd1000);
        repeat (11) @(negedge clk);
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== {P1, P0, P0, P0}) begin n_bad++; $display("FAIL zeros1000_b: got %h want %h", gb, {P1, P0, P0, P0}); end
        n_cmp++; if (!ok || gn !== {P1, P0, P0, P0}) begin n_bad++; $display("FAIL zeros1000_nb: got %h want %h", gn, {P1, P0, P0, P0}); end
    endtask

    task automatic test_reset_mid;
        logic [3:0][6:0] gb, gn;
        bit ok, clean;
        clean = 1'b1;
        pulse_update(10'd888);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (if_b.an !== 4'b1110 || if_b.seg !== P0) begin n_bad++; $display("FAIL rstmid_disp: got %b/%b want 1110/%b", if_b.an, if_b.seg, P0); end
        n_cmp++; if (if_b.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", if_b.busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (if_b.busy !== 1'b0 || if_b.seg === P8 || if_n.seg === P8) clean = 1'b0;
        end
        n_cmp++; if (!clean) begin n_bad++; $display("FAIL rstmid_abandon: got busy or 8 shown want idle and no 888"); end
        capture(gb, gn, ok);
        n_cmp++; if (!ok || gb !== {PB, PB, PB, P0}) begin n_bad++; $display("FAIL rstmid_disp_b: got %h want %h", gb, {PB, PB, PB, P0}); end
        n_cmp++; if (!ok || gn !== {P0, P0, P0, P0}) begin n_bad++; $display("FAIL rstmid_disp_nb: got %h want %h", gn, {P0, P0, P0, P0}); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_max();
        test_blank();
        test_back_to_back();
        test_internal_zeros();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
